// File: rtl/iic_pkg.sv
// Shared definitions for the I2C/SCCB target: FSM state encoding, ACK/NACK
// bus levels and the default 7-bit device address.
package iic_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DEVADDR = 4'd1,
    S_ACK_DEV = 4'd2,
    S_SUBADDR = 4'd3,
    S_ACK_SUB = 4'd4,
    S_WDATA   = 4'd5,
    S_ACK_WR  = 4'd6,
    S_RDATA   = 4'd7,
    S_RACK    = 4'd8,
    S_IGNORE  = 4'd9
  } iic_state_e;

  // SDA level during the 9th clock
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h21;

endpackage

// File: rtl/iic_slave_if.sv
// Bus bundle of the I2C target: raw pad levels, open-drain SDA enable,
// register-port handshake and busy flag.
//   slave  : view of the target (iic_slave)
//   master : view of whatever drives the pads and serves the register port
interface iic_slave_if;

  logic       scl_in;     // raw SCL pad level
  logic       sda_in;     // raw SDA pad level
  logic       sda_oe;     // 1 = pull SDA low
  logic [7:0] reg_addr;   // register pointer of current access
  logic [7:0] reg_wdata;  // write data, valid with reg_we
  logic       reg_we;     // one-cycle write strobe
  logic       reg_re;     // one-cycle read strobe
  logic [7:0] reg_rdata;  // read data, one cycle after reg_re
  logic       busy;       // addressed transfer in progress

  modport slave (
    input  scl_in, sda_in, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

  modport master (
    output scl_in, sda_in, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

endinterface

// File: rtl/iic_in_filt.sv
// Input conditioning for one I2C line: 2-flop synchronizer, glitch filter
// that needs FILT consecutive differing samples before the level flips,
// and single-cycle rise/fall pulses from the filtered level.
//   clk_sys, rst : system clock, synchronous active-high reset
//   pin_i        : raw asynchronous pad level
//   level_o      : filtered level
//   rise_o/fall_o: one-cycle pulses on filtered-level change
module iic_in_filt #(
  parameter int unsigned FILT = 3
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [3:0] CntMax = 4'(FILT - 1);

  logic [1:0] sync_q, sync_d;
  logic       lvl_q, lvl_d;
  logic       prev_q, prev_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], pin_i};
    prev_d = lvl_q;
    lvl_d  = lvl_q;
    cnt_d  = '0;
    // Any sample equal to the current level restarts the count
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CntMax) begin
        lvl_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync_q <= 2'b11;
      lvl_q  <= 1'b1;
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = lvl_q & ~prev_q;
  assign fall_o  = ~lvl_q & prev_q;

endmodule

// File: rtl/iic_slave.sv
// I2C/SCCB target. Filters SCL/SDA, detects START/STOP, matches DEV_ADDR,
// ACKs, and maps transfers onto an 8-bit register port with a retained,
// auto-incrementing pointer (sub-address write, burst write, current-address
// burst read).
//   clk_sys, rst : system clock, synchronous active-high reset
//   bus          : iic_slave_if.slave (pads, register port, busy)
module iic_slave
  import iic_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DEF_DEV_ADDR,
  parameter int unsigned FILT     = 3
) (
  input  logic           clk_sys,
  input  logic           rst,
  iic_slave_if.slave     bus
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  iic_in_filt #(.FILT(FILT)) u_scl_filt (
    .clk_sys (clk_sys),
    .rst     (rst),
    .pin_i   (bus.scl_in),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  iic_in_filt #(.FILT(FILT)) u_sda_filt (
    .clk_sys (clk_sys),
    .rst     (rst),
    .pin_i   (bus.sda_in),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  // SDA edges with SCL high are bus conditions, never data
  logic start_ev, stop_ev;
  assign start_ev = sda_fall & scl_lvl;
  assign stop_ev  = sda_rise & scl_lvl;

  iic_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rw_q, rw_d;
  logic       mack_q, mack_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       rd_cap_q, rd_cap_d;

  logic [7:0] rx_in;
  assign rx_in = {rx_q, sda_lvl};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    mack_d    = mack_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    rd_cap_d  = re_q;

    // Pointer advances the cycle after the write strobe
    if (we_q) ptr_d = ptr_q + 8'd1;
    // User returns read data one cycle after reg_re
    if (rd_cap_q) tx_d = bus.reg_rdata;

    if (stop_ev) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
    end else if (start_ev) begin
      state_d   = S_DEVADDR;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_IGNORE: ;

        S_DEVADDR: begin
          if (scl_rise) begin
            rx_d      = rx_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (rx_in[7:1] == DEV_ADDR) begin
                busy_d  = 1'b1;
                rw_d    = rx_in[0];
                re_d    = rx_in[0];
                state_d = S_ACK_DEV;
              end else begin
                state_d = S_IGNORE;
              end
            end
          end
        end

        // bit_cnt 0: waiting for the fall after bit 8; 1: driving the 9th clock
        S_ACK_DEV, S_ACK_SUB, S_ACK_WR: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              oe_d      = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              oe_d      = 1'b0;
              bit_cnt_d = '0;
              if (state_q == S_ACK_DEV && rw_q) begin
                state_d = S_RDATA;
                oe_d    = ~tx_q[7];
              end else if (state_q == S_ACK_DEV) begin
                state_d = S_SUBADDR;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end

        S_SUBADDR: begin
          if (scl_rise) begin
            rx_d      = rx_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              ptr_d     = rx_in;
              state_d   = S_ACK_SUB;
            end
          end
        end

        S_WDATA: begin
          if (scl_rise) begin
            rx_d      = rx_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              we_d      = 1'b1;
              wdata_d   = rx_in;
              state_d   = S_ACK_WR;
            end
          end
        end

        // MSB was put out on entry; each later fall shifts the next bit out
        S_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              oe_d      = 1'b0;
              bit_cnt_d = '0;
              state_d   = S_RACK;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
              oe_d = ~tx_q[6];
            end
          end
        end

        S_RACK: begin
          if (scl_rise) begin
            mack_d = (sda_lvl == ACK);
            ptr_d  = ptr_q + 8'd1;
            re_d   = (sda_lvl == ACK);
          end else if (scl_fall) begin
            if (mack_q) begin
              state_d = S_RDATA;
              oe_d    = ~tx_q[7];
            end else begin
              state_d = S_IGNORE;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      mack_q    <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      rd_cap_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      mack_q    <= mack_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      re_q      <= re_d;
      rd_cap_q  <= rd_cap_d;
    end
  end

  assign bus.sda_oe    = oe_q;
  assign bus.reg_addr  = ptr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_iic_slave.sv
// Bench for iic_slave: bus-functional I2C master, register-file responder,
// and a transaction-level model (pointer + register array) for expectations.
module tb_iic_slave;
  import iic_pkg::*;

  localparam int Q = 15;  // quarter SCL period in clk_sys cycles
  localparam logic [6:0] DEV = 7'h21;

  logic clk_sys = 1'b0;
  logic rst = 1'b1;
  always #10 clk_sys = ~clk_sys;

  iic_slave_if bus ();

  iic_slave #(.DEV_ADDR(DEV), .FILT(3)) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus)
  );

  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;  // wired-AND open drain

  logic [7:0] mem [256];
  always @(posedge clk_sys) if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];

  // Strobe monitor
  logic [15:0] we_log[$];
  logic [7:0]  re_log[$];
  int   oe_cycles = 0;
  int   pulse_err = 0;
  logic prev_we = 1'b0, prev_re = 1'b0;
  always @(negedge clk_sys) begin
    if (bus.reg_we) we_log.push_back({bus.reg_addr, bus.reg_wdata});
    if (bus.reg_re) re_log.push_back(bus.reg_addr);
    if ((bus.reg_we && prev_we) || (bus.reg_re && prev_re) || (bus.reg_we && bus.reg_re))
      pulse_err <= pulse_err + 1;
    if (bus.sda_oe) oe_cycles <= oe_cycles + 1;
    prev_we <= bus.reg_we;
    prev_re <= bus.reg_re;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- bus master ----------------
  task automatic clks(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  task automatic bit_tx(input logic b, input logic glitch);
    clks(Q); m_sda = b; clks(Q); m_scl = 1'b1;
    if (glitch) begin
      clks(10); m_scl = 1'b0; clks(2); m_scl = 1'b1; clks(2 * Q - 12);
    end else begin
      clks(2 * Q);
    end
    m_scl = 1'b0;
  endtask

  task automatic bit_rx(output logic b);
    clks(Q); m_sda = 1'b1; clks(Q); m_scl = 1'b1; clks(Q);
    @(negedge clk_sys); b = bus.sda_in;
    clks(Q); m_scl = 1'b0;
  endtask

  task automatic start_c();
    clks(Q); m_sda = 1'b1; clks(Q); m_scl = 1'b1; clks(Q); m_sda = 1'b0; clks(Q); m_scl = 1'b0;
  endtask

  task automatic stop_c();
    clks(Q); m_sda = 1'b0; clks(Q); m_scl = 1'b1; clks(Q); m_sda = 1'b1; clks(Q);
  endtask

  task automatic byte_tx(input logic [7:0] d, input int glitch_at, output logic ack);
    for (int i = 7; i >= 0; i--) bit_tx(d[i], i == glitch_at);
    bit_rx(ack);
  endtask

  task automatic byte_rx(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_rx(b);
      d[i] = b;
    end
    bit_tx(ack, 1'b0);
  endtask

  // ---------------- reference model + transactions ----------------
  logic [7:0] ptr_m = 8'h00;
  logic [7:0] wdat[4];

  task automatic txn_write(input logic [6:0] dev, input logic [7:0] sub, input int n,
                           input int glitch_byte);
    int          we0, re0, oe0;
    logic        hit, ack;
    logic [15:0] exp_w[$];
    logic [31:0] got;
    we0 = we_log.size(); re0 = re_log.size(); oe0 = oe_cycles;
    hit = (dev == DEV);
    start_c();
    byte_tx({dev, 1'b0}, -1, ack);
    check_eq("wr_dev_ack", 32'(ack), 32'(hit ? ACK : NACK));
    byte_tx(sub, -1, ack);
    check_eq("wr_sub_ack", 32'(ack), 32'(hit ? ACK : NACK));
    if (hit) ptr_m = sub;
    for (int i = 0; i < n; i++) begin
      byte_tx(wdat[i], (i == glitch_byte) ? 3 : -1, ack);
      check_eq("wr_data_ack", 32'(ack), 32'(hit ? ACK : NACK));
      if (hit) begin
        exp_w.push_back({ptr_m, wdat[i]});
        mem[ptr_m] = wdat[i];
        ptr_m = ptr_m + 8'd1;
      end
    end
    @(negedge clk_sys);
    check_eq("wr_busy_in", 32'(bus.busy), 32'(hit));
    stop_c(); clks(10);
    @(negedge clk_sys);
    check_eq("wr_busy_end", 32'(bus.busy), 32'd0);
    check_eq("wr_count", 32'(we_log.size() - we0), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) begin
      got = 32'hFFFF_FFFF;
      if (we0 + i < we_log.size()) got = {16'h0, we_log[we0 + i]};
      check_eq("wr_evt", got, {16'h0, exp_w[i]});
    end
    check_eq("wr_no_re", 32'(re_log.size() - re0), 32'd0);
    if (!hit) check_eq("miss_oe", 32'(oe_cycles - oe0), 32'd0);
  endtask

  task automatic txn_read(input logic set_sub, input logic [7:0] sub, input int n);
    int          we0, re0;
    logic        ack;
    logic [7:0]  b;
    logic [7:0]  exp_r[$];
    logic [31:0] got;
    we0 = we_log.size(); re0 = re_log.size();
    start_c();
    if (set_sub) begin
      byte_tx({DEV, 1'b0}, -1, ack);
      check_eq("rd_wdev_ack", 32'(ack), 32'(ACK));
      byte_tx(sub, -1, ack);
      check_eq("rd_sub_ack", 32'(ack), 32'(ACK));
      ptr_m = sub;
      start_c();
    end
    byte_tx({DEV, 1'b1}, -1, ack);
    check_eq("rd_dev_ack", 32'(ack), 32'(ACK));
    for (int i = 0; i < n; i++) begin
      byte_rx(b, (i == n - 1) ? NACK : ACK);
      check_eq("rd_data", 32'(b), 32'(mem[ptr_m]));
      exp_r.push_back(ptr_m);
      ptr_m = ptr_m + 8'd1;
    end
    @(negedge clk_sys);
    check_eq("rd_busy_in", 32'(bus.busy), 32'd1);
    stop_c(); clks(10);
    @(negedge clk_sys);
    check_eq("rd_busy_end", 32'(bus.busy), 32'd0);
    check_eq("rd_count", 32'(re_log.size() - re0), 32'(exp_r.size()));
    for (int i = 0; i < exp_r.size(); i++) begin
      got = 32'hFFFF_FFFF;
      if (re0 + i < re_log.size()) got = 32'(re_log[re0 + i]);
      check_eq("rd_addr", got, 32'(exp_r[i]));
    end
    check_eq("rd_no_we", 32'(we_log.size() - we0), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_oe"},    32'(bus.sda_oe),    32'd0);
    check_eq({tag, "_we"},    32'(bus.reg_we),    32'd0);
    check_eq({tag, "_re"},    32'(bus.reg_re),    32'd0);
    check_eq({tag, "_busy"},  32'(bus.busy),      32'd0);
    check_eq({tag, "_addr"},  32'(bus.reg_addr),  32'd0);
    check_eq({tag, "_wdata"}, 32'(bus.reg_wdata), 32'd0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] v;
    int         we0;
    logic [6:0] dev;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h0A] = 8'h5A;
    mem[8'h0B] = 8'hA5;

    clks(4);
    @(negedge clk_sys);
    check_reset_outputs("rst");
    rst = 1'b0;
    clks(10);

    // Directed single write
    wdat[0] = 8'h80;
    txn_write(DEV, 8'h12, 1, -1);
    // Address miss
    txn_write(7'h30, 8'h12, 0, -1);
    // Read burst from 0x0A: expects 0x5A then 0xA5
    txn_read(1'b1, 8'h0A, 2);
    // Pointer wrap
    wdat[0] = 8'h11; wdat[1] = 8'h22;
    txn_write(DEV, 8'hFF, 2, -1);

    // Abort after 4 data bits: no write, FSM back to idle
    we0 = we_log.size();
    start_c();
    byte_tx({DEV, 1'b0}, -1, ack);
    byte_tx(8'h30, -1, ack);
    ptr_m = 8'h30;
    for (int i = 0; i < 4; i++) bit_tx(1'($urandom), 1'b0);
    stop_c(); clks(10);
    @(negedge clk_sys);
    check_eq("abort_no_we", 32'(we_log.size() - we0), 32'd0);
    check_eq("abort_state", 32'(dut.state_q), 32'(S_IDLE));
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    txn_read(1'b0, 8'h00, 1);

    // SCL glitch during a data bit
    wdat[0] = 8'($urandom); wdat[1] = 8'($urandom);
    txn_write(DEV, 8'h40, 2, 0);

    // Reset while driving an ACK
    start_c();
    v = {DEV, 1'b0};
    for (int i = 7; i >= 0; i--) bit_tx(v[i], 1'b0);
    clks(Q);
    @(negedge clk_sys);
    check_eq("ack_drive", 32'(bus.sda_oe), 32'd1);
    rst = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check_reset_outputs("midrst");
    ptr_m = 8'h00;
    m_scl = 1'b1; m_sda = 1'b1;
    clks(10);
    rst = 1'b0;
    clks(10);
    txn_read(1'b0, 8'h00, 1);

    // Randomized transactions
    for (int k = 0; k < 6; k++) begin
      case ($urandom_range(0, 3))
        0: begin
          for (int i = 0; i < 3; i++) wdat[i] = 8'($urandom);
          txn_write(DEV, 8'($urandom), $urandom_range(1, 3), -1);
        end
        1: begin
          dev = 7'($urandom);
          if (dev == DEV) dev = DEV + 7'd1;
          wdat[0] = 8'($urandom);
          txn_write(dev, 8'($urandom), 1, -1);
        end
        2: txn_read(1'b0, 8'h00, $urandom_range(1, 3));
        default: txn_read(1'b1, 8'($urandom), $urandom_range(1, 3));
      endcase
    end

    check_eq("strobe_shape", 32'(pulse_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
